// File: rtl/fft_spectrum_capture.sv
// Spectrum capture behind the windowed-FFT stage: drains one frame of bins,
// post-processes each bin (live/average/peak) and serves a registered read port.
module fft_spectrum_capture #(
    parameter int RN   = 16,
    parameter int SIZE = 64,
    parameter int AVG  = 3,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fft_done,
    output logic          fft_shift,
    input  logic [RN-1:0] fft_data,
    input  logic [1:0]    mode,
    input  logic          clear,
    input  logic [AW-1:0] rd_addr,
    output logic [RN-1:0] rd_data,
    output logic          busy,
    output logic          frame,
    output logic [7:0]    dropped
);

    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

    state_t          state;
    logic [CW-1:0]   cyc;
    logic [1:0]      mode_q;
    logic            seed;
    logic [RN-1:0]   store [SIZE];

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [RN-1:0]   old;
    logic [RN-1:0]   wr_val;
    logic signed [RN:0] diff;
    logic signed [RN:0] step_v;

    // cyc holds the index of the current cycle relative to fft_done (c0)
    always_comb begin
        wr_en   = busy && (cyc >= CW'(2));
        wr_addr = AW'(cyc - CW'(2));
        old     = store[wr_addr];
        diff    = $signed({1'b0, fft_data}) - $signed({1'b0, old});
        step_v  = diff >>> AVG;
        wr_val  = fft_data;
        if (!seed) begin
            case (mode_q)
                2'd1:    wr_val = RN'($unsigned({1'b0, old}) + $unsigned(step_v));
                2'd2:    wr_val = (old > fft_data) ? old : fft_data;
                default: wr_val = fft_data;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cyc       <= '0;
            mode_q    <= '0;
            seed      <= 1'b1;
            fft_shift <= 1'b0;
            busy      <= 1'b0;
            frame     <= 1'b0;
            dropped   <= '0;
            rd_data   <= '0;
            for (int i = 0; i < SIZE; i++) store[i] <= '0;
        end else begin
            frame   <= 1'b0;
            rd_data <= store[rd_addr];
            if (fft_done && state != IDLE && dropped != 8'hff)
                dropped <= dropped + 8'd1;
            unique case (state)
                IDLE: begin
                    if (fft_done) begin
                        state     <= SHIFT;
                        cyc       <= CW'(1);
                        mode_q    <= mode;
                        fft_shift <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    cyc <= cyc + CW'(1);
                    if (cyc == CW'(SIZE - 1)) begin
                        state     <= TAIL;
                        fft_shift <= 1'b0;
                    end
                end
                TAIL: begin
                    cyc <= cyc + CW'(1);
                    if (cyc == CW'(SIZE + 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        frame <= 1'b1;
                        seed  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // clear zeroes everything, but a same-edge capture write wins
            if (clear) begin
                for (int i = 0; i < SIZE; i++) store[i] <= '0;
                seed <= 1'b1;
            end
            if (wr_en) store[wr_addr] <= wr_val;
        end
    end

endmodule

// File: tb/tb_fft_spectrum_capture.sv
// Bench for fft_spectrum_capture: small FFT-stage model, store model and
// a read-back scoreboard queue.
module tb_fft_spectrum_capture;

    localparam int RN   = 8;
    localparam int SIZE = 4;
    localparam int AVG  = 2;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fft_done = 1'b0;
    logic          fft_shift;
    logic [RN-1:0] fft_data;
    logic [1:0]    mode = 2'd0;
    logic          clear = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [RN-1:0] rd_data;
    logic          busy;
    logic          frame;
    logic [7:0]    dropped;

    fft_spectrum_capture #(.RN(RN), .SIZE(SIZE), .AVG(AVG), .AW(AW)) dut (
        .clk(clk), .reset(reset), .fft_done(fft_done), .fft_shift(fft_shift),
        .fft_data(fft_data), .mode(mode), .clear(clear), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .frame(frame), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // FFT stage model: registered bin latch advanced by fft_shift
    logic [RN-1:0] drv [SIZE];
    logic [RN-1:0] lat [SIZE];
    logic [AW-1:0] ptr = '0;
    logic          load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            lat      <= drv;
            ptr      <= '0;
            fft_data <= drv[0];
        end else begin
            fft_data <= lat[ptr];
            if (fft_shift) ptr <= ptr + 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;
    int exp_st [SIZE];
    bit seed_m = 1'b1;
    int drop_m = 0;
    int sb_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < SIZE; k++) exp_st[k] = 0;
        seed_m = 1'b1;
        drop_m = 0;
    endtask

    task automatic read_store(input string tag);
        for (int k = 0; k < SIZE; k++) begin
            rd_addr = AW'(k);
            sb_q.push_back(exp_st[k]);
            step();
            chk($sformatf("%s_rd%0d", tag, k), 32'(rd_data), 32'(sb_q.pop_front()));
        end
    endtask

    // Caller is positioned inside the cycle that becomes c0.
    task automatic run_frame(input string tag, input int b0, input int b1,
                             input int b2, input int b3, input int md,
                             input int clr_at, input int drop_at);
        int b [SIZE];
        int nsh, first, last, fcyc, o, v, wc;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int k = 0; k < SIZE; k++) begin
            o  = exp_st[k];
            wc = k + 2;
            if (clr_at > 0 && wc > clr_at) v = b[k];
            else if (seed_m || md == 0 || md == 3) v = b[k];
            else if (md == 1) v = o + ((b[k] - o) >>> AVG);
            else v = (o > b[k]) ? o : b[k];
            if (clr_at > 0 && wc < clr_at) v = 0;
            exp_st[k] = v;
            drv[k] = RN'(b[k]);
        end
        seed_m = 1'b0;
        if (drop_at > 0) drop_m++;
        mode = 2'(md);
        fft_done = 1'b1;
        load = 1'b1;
        nsh = 0; first = -1; last = -1; fcyc = -1;
        for (int n = 1; n <= 16; n++) begin
            step();
            fft_done = 1'b0;
            load = 1'b0;
            clear = 1'b0;
            if (n == 1) chk({tag, "_busy_c1"}, 32'(busy), 1);
            if (fft_shift) begin
                nsh++;
                if (first < 0) first = n;
                last = n;
            end
            if (n == drop_at) fft_done = 1'b1;
            if (n == clr_at) clear = 1'b1;
            if (frame) begin
                fcyc = n;
                break;
            end
        end
        chk({tag, "_frame_cyc"}, 32'(fcyc), SIZE + 2);
        chk({tag, "_nshift"}, 32'(nsh), SIZE - 1);
        chk({tag, "_shift_first"}, 32'(first), 1);
        chk({tag, "_shift_last"}, 32'(last), SIZE - 1);
        chk({tag, "_busy_frame"}, 32'(busy), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame", 32'(frame), 0);
        chk("rst_shift", 32'(fft_shift), 0);
        chk("rst_dropped", 32'(dropped), 0);
        reset = 1'b0;
        step();

        run_frame("seed", 40, 80, 120, 200, 1, 0, 0);
        read_store("seed");
        run_frame("avg", 80, 80, 0, 200, 1, 0, 0);
        read_store("avg");
        run_frame("peak", 60, 10, 255, 0, 2, 0, 0);
        read_store("peak");

        run_frame("drop", 1, 2, 3, 4, 0, 0, 3);
        chk("drop_count", 32'(dropped), 32'(drop_m));
        // started in the frame cycle of the previous drain
        run_frame("b2b", 5, 1, 9, 2, 2, 0, 0);
        read_store("b2b");

        run_frame("clr", 100, 60, 30, 20, 1, 3, 0);
        read_store("clr");
        run_frame("postclr", 40, 16, 70, 20, 1, 0, 0);
        read_store("postclr");
        step();

        run_frame("m3", 11, 12, 13, 14, 3, 0, 0);
        read_store("m3");
        step();

        // reset arriving mid-drain, in c2
        drv[0] = 8'd9; drv[1] = 8'd9; drv[2] = 8'd9; drv[3] = 8'd9;
        mode = 2'd1;
        fft_done = 1'b1;
        load = 1'b1;
        step();
        fft_done = 1'b0;
        load = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_shift", 32'(fft_shift), 0);
        chk("mrst_frame", 32'(frame), 0);
        chk("mrst_dropped", 32'(dropped), 0);
        chk("mrst_rd", 32'(rd_data), 0);
        model_reset();
        step();
        reset = 1'b0;
        step();
        read_store("mrst");
        run_frame("after", 7, 8, 9, 10, 1, 0, 0);
        read_store("after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
